// File: rtl/march_fail_logger_if.sv
// Compare-strobe, control and log-drain bundle for march_fail_logger.
// Log entries are {addr, syndrome} with FAIL_LOG_SYNDROME_EN defined, otherwise addr only.
interface march_fail_logger_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 9
);
`ifdef FAIL_LOG_SYNDROME_EN
  localparam int LOG_W = ADDR_W + DATA_W;
`else
  localparam int LOG_W = ADDR_W;
`endif

  logic              start;
  logic              test_end;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp;
  logic [DATA_W-1:0] cmp_got;
  logic              go_nogo;
  logic              overflow;
  logic [CNT_W-1:0]  fail_count;
  logic              done;
  logic              log_valid;
  logic [LOG_W-1:0]  log_data;
  logic              log_ready;

  modport master (
    output start, test_end, cmp_valid, cmp_addr, cmp_exp, cmp_got, log_ready,
    input  go_nogo, overflow, fail_count, done, log_valid, log_data
  );

  modport slave (
    input  start, test_end, cmp_valid, cmp_addr, cmp_exp, cmp_got, log_ready,
    output go_nogo, overflow, fail_count, done, log_valid, log_data
  );
endinterface

// File: rtl/march_fail_logger.sv
// March BIST fail logger: FWFT log of failing reads, saturating count, sticky flags.
// FAIL_LOG_SYNDROME_EN adds the exp^got syndrome to each log entry.
module march_fail_logger #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 9
) (
  input  logic               clk,
  input  logic               rst,
  march_fail_logger_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
`ifdef FAIL_LOG_SYNDROME_EN
  localparam int LOG_W = ADDR_W + DATA_W;
`else
  localparam int LOG_W = ADDR_W;
`endif

  typedef enum logic [1:0] {IDLE, ARMED, FINISHED} state_t;

  state_t           state_q;
  logic [LOG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             go_q, ovf_q, done_q;
  logic [DATA_W-1:0] syn;
  logic             full, pop, fail_ev, push, drop;
  logic [LOG_W-1:0] entry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // start wins over a same-cycle compare, so it never produces a fail event
  always_comb begin
    syn        = bus.cmp_exp ^ bus.cmp_got;
    full       = (occ_q == OCC_W'(DEPTH));
    pop        = (occ_q != '0) && bus.log_ready;
    fail_ev    = (state_q == ARMED) && bus.cmp_valid && (syn != '0) && !bus.start;
    push       = fail_ev && (!full || pop);
    drop       = fail_ev && !push;
    fail_cnt_d = sat_inc(fail_cnt_q);
    occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
  end

`ifdef FAIL_LOG_SYNDROME_EN
  assign entry = {bus.cmp_addr, syn};
`else
  assign entry = bus.cmp_addr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      fail_cnt_q <= '0;
      go_q       <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.start) begin
      state_q    <= ARMED;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      fail_cnt_q <= '0;
      go_q       <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fail_ev) begin
        go_q       <= 1'b1;
        fail_cnt_q <= fail_cnt_d;
      end
      if (drop) ovf_q <= 1'b1;
      case (state_q)
        ARMED: if (bus.test_end) begin
          state_q <= FINISHED;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Log storage carries no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  assign bus.go_nogo    = go_q;
  assign bus.overflow   = ovf_q;
  assign bus.fail_count = fail_cnt_q;
  assign bus.done       = done_q;
  assign bus.log_valid  = (occ_q != '0);
  assign bus.log_data   = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_march_fail_logger.sv
// Scoreboard bench for march_fail_logger: queue-based reference model plus directed and random stimulus.
module tb_march_fail_logger;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef FAIL_LOG_SYNDROME_EN
  localparam int LOG_W = ADDR_W + DATA_W;
`else
  localparam int LOG_W = ADDR_W;
`endif
  localparam int S_IDLE = 0, S_ARMED = 1, S_FIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  march_fail_logger_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  march_fail_logger #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [LOG_W-1:0] mq[$];
  int m_state = S_IDLE;
  int m_cnt   = 0;
  bit m_go    = 1'b0;
  bit m_ovf   = 1'b0;

  function automatic logic [LOG_W-1:0] mk(input logic [ADDR_W-1:0] a,
                                          input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] g);
    logic [ADDR_W+DATA_W-1:0] w;
    w = {a, e ^ g};
    return w[ADDR_W+DATA_W-1 -: LOG_W];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: plain queue and counters, updated on every rising edge
  initial begin
    bit p, f, fu;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_state = S_IDLE; mq.delete(); m_cnt = 0; m_go = 0; m_ovf = 0;
      end else if (bus.start) begin
        m_state = S_ARMED; mq.delete(); m_cnt = 0; m_go = 0; m_ovf = 0;
      end else begin
        p  = (mq.size() > 0) && bus.log_ready;
        fu = (mq.size() == DEPTH);
        f  = (m_state == S_ARMED) && bus.cmp_valid && (bus.cmp_exp != bus.cmp_got);
        if (p) void'(mq.pop_front());
        if (f) begin
          m_go = 1;
          if (m_cnt < CMAX) m_cnt++;
          if (!fu || p) mq.push_back(mk(bus.cmp_addr, bus.cmp_exp, bus.cmp_got));
          else m_ovf = 1;
        end
        if (m_state == S_ARMED && bus.test_end) m_state = S_FIN;
      end
    end
  end

  // Monitor: compares every visible output against the model on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      chk("go_nogo", 32'(bus.go_nogo), 32'(m_go));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("fail_count", 32'(bus.fail_count), 32'(m_cnt));
      chk("done", 32'(bus.done), 32'(m_state == S_FIN));
      chk("log_valid", 32'(bus.log_valid), 32'(mq.size() != 0));
      if (bus.log_valid === 1'b1 && mq.size() != 0)
        chk("log_data", 32'(bus.log_data), 32'(mq[0]));
    end
  end

  task automatic drive(input bit st, input bit te, input bit v, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] g, input bit rdy);
    bus.start = st; bus.test_end = te; bus.cmp_valid = v;
    bus.cmp_addr = a; bus.cmp_exp = e; bus.cmp_got = g; bus.log_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit rdy);
    drive(0, 0, 0, '0, '0, '0, rdy);
  endtask

  task automatic fail_at(input logic [ADDR_W-1:0] a, input bit rdy);
    drive(0, 0, 1, a, 4'h5, 4'h6, rdy);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    drive(0, 0, 0, '0, '0, '0, 0);
    idle(0);
    chk("reset_log_valid", 32'(bus.log_valid), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    // Clean run
    drive(1, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 256; i++) begin
      d = DATA_W'($urandom());
      drive(0, 0, 1, ADDR_W'(i), d, d, 0);
    end
    drive(0, 1, 0, '0, '0, '0, 0);
    chk("clean_done", 32'(bus.done), 32'd1);
    chk("clean_go", 32'(bus.go_nogo), 32'd0);
    chk("clean_cnt", 32'(bus.fail_count), 32'd0);
    idle(0);

    // Single fault
    drive(1, 0, 0, '0, '0, '0, 0);
    chk("rearm_done", 32'(bus.done), 32'd0);
    drive(0, 0, 1, 8'h3C, 4'hA, 4'h8, 0);
    chk("single_go", 32'(bus.go_nogo), 32'd1);
    chk("single_cnt", 32'(bus.fail_count), 32'd1);
    chk("single_data", 32'(bus.log_data), 32'(mk(8'h3C, 4'hA, 4'h8)));
    idle(1);
    chk("single_popped", 32'(bus.log_valid), 32'd0);

    // Overflow
    drive(1, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 10; i++) fail_at(ADDR_W'(i), 0);
    chk("ovf_cnt", 32'(bus.fail_count), 32'd10);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_addr", 32'(bus.log_data[LOG_W-1 -: ADDR_W]), 32'(i));
      idle(1);
    end
    chk("ovf_drained", 32'(bus.log_valid), 32'd0);

    // Full with simultaneous pop
    drive(1, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 8; i++) fail_at(ADDR_W'(8'h10 + i), 0);
    fail_at(8'hF0, 1);
    chk("fullpop_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("fullpop_valid", 32'(bus.log_valid), 32'd1);
      if (i == 7) chk("fullpop_last", 32'(bus.log_data[LOG_W-1 -: ADDR_W]), 32'h0F0);
      idle(1);
    end
    chk("fullpop_empty", 32'(bus.log_valid), 32'd0);

    // Priority
    drive(1, 0, 0, '0, '0, '0, 0);
    fail_at(8'h01, 0);
    drive(1, 0, 1, 8'h02, 4'h3, 4'hC, 0);
    chk("prio_start_cnt", 32'(bus.fail_count), 32'd0);
    chk("prio_start_log", 32'(bus.log_valid), 32'd0);
    drive(0, 1, 1, 8'h77, 4'h1, 4'h0, 0);
    chk("prio_end_done", 32'(bus.done), 32'd1);
    chk("prio_end_log", 32'(bus.log_data[LOG_W-1 -: ADDR_W]), 32'h077);
    fail_at(8'h78, 0);
    chk("finished_ignores", 32'(bus.fail_count), 32'd1);

    // Saturation, then reset mid-run
    drive(1, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 20; i++) fail_at(ADDR_W'(i), ($urandom_range(0, 1) == 1));
    chk("sat_cnt", 32'(bus.fail_count), 32'd15);
    rst = 1'b1;
    fail_at(8'h55, 0);
    rst = 1'b0;
    chk("rst_cnt", 32'(bus.fail_count), 32'd0);
    chk("rst_go", 32'(bus.go_nogo), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_valid", 32'(bus.log_valid), 32'd0);
    fail_at(8'h56, 0);
    chk("idle_ignores", 32'(bus.fail_count), 32'd0);

    // Random traffic
    drive(1, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 800; i++) begin
      logic [DATA_W-1:0] e, g;
      e = DATA_W'($urandom());
      g = ($urandom_range(0, 2) == 0) ? DATA_W'($urandom()) : e;
      rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 1) == 1), ADDR_W'($urandom()), e, g,
            ($urandom_range(0, 2) == 0));
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) idle(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/march_fail_logger.md
# march_fail_logger

Downstream result stage of the March LR BIST datapath. It replaces the one-bit sticky flag with a logging stage that collects per-read compare results. Each failing compare is logged as {address, syndrome} into a small first-word-fall-through FIFO. The stage keeps a saturating fail count, sticky go/no-go and overflow flags, and a done indication, and a host or scan controller drains the log through a valid/ready port.

## Interface
Parameters:
- ADDR_W, 8, SRAM address width
- DATA_W, 4, SRAM word width
- DEPTH, 8, log entries (power of two, ≥2)
- CNT_W, 9, fail counter width

Ports:
- clk  input  1  sole clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: clear log, count and flags, arm logging
- test_end  input  1  one-cycle pulse from the March counter: last read element done
- cmp_valid  input  1  read-compare strobe (high only on read cycles)
- cmp_addr  input  ADDR_W  address of the compared word
- cmp_exp  input  DATA_W  expected data from the March counter
- cmp_got  input  DATA_W  data read from SRAM
- go_nogo  output  1  sticky; 1 = at least one failure since start
- overflow  output  1  sticky; 1 = a failure was dropped because the log was full
- fail_count  output  CNT_W  failures since start, saturating
- done  output  1  high while in FINISHED
- log_valid  output  1  log non-empty
- log_data  output  ADDR_W+DATA_W (ADDR_W without syndrome)  head entry {addr, syndrome}
- log_ready  input  1  pop head when log_valid && log_ready

## Operation
- States: IDLE, ARMED, FINISHED. rst → IDLE.
- IDLE: start → ARMED. Everything else is ignored except pops.
- ARMED: test_end → FINISHED.
- FINISHED: start → ARMED (re-arm).
- start has priority in every state.
  - It empties the log.
  - It zeroes fail_count, go_nogo and overflow.
  - A cmp_valid in the same cycle is discarded.
- A fail event requires all of: ARMED, cmp_valid = 1, cmp_exp ≠ cmp_got. On a fail event:
  - go_nogo ← 1.
  - fail_count ← fail_count+1, holding at 2^CNT_W−1.
  - Push {cmp_addr, cmp_exp ^ cmp_got}, or set overflow if no slot is available.
- Slot availability: a push is accepted if the log is not full, or if it is full and a pop happens in the same cycle. In the full-with-pop case the occupancy stays at DEPTH.
- A cmp_valid with matching data changes nothing.
- cmp_valid in IDLE or FINISHED is ignored.
- test_end together with a fail event in ARMED: the event is logged, then the state moves to FINISHED.
- Pop while empty: no effect. Pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH)+1.
- Pops are allowed in any state, including during ARMED logging.

## Timing
- Reset values:
  - State: IDLE.
  - go_nogo, overflow, done, log_valid: 0.
  - fail_count: 0.
  - log_data: don't-care; bench checks it only when log_valid = 1.
- A fail event sampled at edge N updates go_nogo, fail_count, overflow and log_valid after edge N (1-cycle latency).
- FWFT: log_data shows the head entry combinationally from registered storage. After a pop at edge N, the next entry is visible after edge N.
- done rises the cycle after the test_end edge. It falls the cycle after start.
- rst asserted mid-test: state returns to IDLE at that edge, and log contents are discarded.

## Configuration
- FAIL_LOG_SYNDROME_EN defined:
  - Each entry is {cmp_addr, cmp_exp^cmp_got}.
  - log_data is ADDR_W+DATA_W bits.
- Not defined:
  - Entries hold cmp_addr only.
  - log_data is ADDR_W bits.
  - No syndrome storage is built.
- Counting, flags and handshake are identical in both builds.

## Test plan
- Clean run:
  - Stimulus: rst, start, 256 reads with cmp_exp = cmp_got, test_end.
  - Expected: go_nogo = 0, fail_count = 0, log_valid = 0, done = 1 one cycle after test_end.
- Single fault:
  - Stimulus: ARMED, cmp_addr = 8'h3C, exp = 4'hA, got = 4'h8.
  - Expected next cycle: go_nogo = 1, fail_count = 1, log_valid = 1, log_data = {8'h3C, 4'h2}.
  - After log_ready = 1: log_valid = 0.
- Overflow:
  - Stimulus: 10 fails at addresses 0..9, DEPTH = 8, no pops.
  - Expected: fail_count = 10, overflow = 1.
  - Drain yields addresses 0..7 in order.
- Full with simultaneous pop:
  - Stimulus: log full, fail at address 8'hF0 with log_ready = 1.
  - Expected: overflow stays 0, occupancy stays 8, last entry drained is 8'hF0.
- Priority:
  - Stimulus: start together with a failing cmp_valid.
  - Expected: fail_count = 0, log empty.
  - Stimulus: test_end together with a fail.
  - Expected: entry logged, done = 1.
- Saturation:
  - Stimulus: CNT_W = 4, 20 fails.
  - Expected: fail_count = 15.
  - Stimulus: rst mid-run.
  - Expected next cycle: all outputs at reset values.
